memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles spent in REQ awaiting dmem_ack (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  SHALL act as an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be a one-cycle pulse marking valid operation inputs from the execute stage.
REQ-005 mem_read  input  1  SHALL request a load when sampled with start.
REQ-006 mem_write  input  1  SHALL request a store when sampled with start.
REQ-007 halt  input  1  SHALL request a halt when sampled with start.
REQ-008 alu_in  input  16  SHALL carry the ALU result: the address for load/store, passthrough data otherwise.
REQ-009 wr_data  input  16  SHALL carry the store data.
REQ-010 dmem_req  output  1  SHALL be the data-memory request.
REQ-011 dmem_we  output  1  SHALL be the data-memory write enable.
REQ-012 dmem_addr  output  16  SHALL be the data-memory address.
REQ-013 dmem_wdata  output  16  SHALL be the data-memory write data.
REQ-014 dmem_rdata  input  16  SHALL be the data-memory read data, valid while dmem_ack=1.
REQ-015 dmem_ack  input  1  SHALL be the data-memory completion strobe.
REQ-016 wb_data  output  16  SHALL be the writeback result, valid while done=1 and held until the next done.
REQ-017 done  output  1  SHALL be a one-cycle completion pulse.
REQ-018 busy  output  1  SHALL be 1 whenever state is not IDLE.
REQ-019 err  output  1  SHALL be the error flag, qualified by done.
REQ-020 halted  output  1  SHALL be a sticky halt indicator.

Function
REQ-021 FSM states SHALL be IDLE, REQ, HALTED; all outputs SHALL be registered.
REQ-022 IDLE, start=1, halt=1: SHALL go to HALTED, pulse done next cycle with err=0 and wb_data=alu_in, and set halted=1; mem_read/mem_write ignored.
REQ-023 IDLE, start=1, mem_read=1 and mem_write=1: SHALL not access memory; next cycle done=1, err=1, wb_data=16'h0000.
REQ-024 IDLE, start=1, mem_read or mem_write with alu_in[0]=1 (misaligned): SHALL not access memory; next cycle done=1, err=1, wb_data=16'h0000.
REQ-025 IDLE, start=1, no read/write/halt: SHALL pulse done next cycle (latency 1) with wb_data=alu_in, err=0.
REQ-026 IDLE, start=1, legal load/store: SHALL go to REQ next cycle with dmem_req=1, dmem_addr=alu_in, dmem_we=mem_write, dmem_wdata=wr_data (16'h0000 for loads).
REQ-027 In REQ, dmem_req/we/addr/wdata SHALL stay stable until the cycle after dmem_ack is sampled 1.
REQ-028 REQ with dmem_ack=1: SHALL return to IDLE, drop dmem_req and pulse done next cycle, err=0, wb_data=dmem_rdata (load) or 16'h0000 (store).
REQ-029 Minimum load/store latency SHALL be 2 cycles, start edge to done (ack in first REQ cycle).
REQ-030 An 8-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; when it reaches TIMEOUT-1 with no ack, the block SHALL return to IDLE, drop dmem_req and pulse done with err=1, wb_data=16'h0000.
REQ-031 dmem_ack arriving in the same cycle as timeout SHALL win: normal completion, err=0.
REQ-032 start while busy=1 SHALL be ignored with no state change; dmem_ack outside REQ SHALL be ignored.
REQ-033 HALTED SHALL be left only by reset; start is ignored there and busy=1.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and clear the counter and all outputs to 0 (wb_data=16'h0000), including mid-REQ; the in-flight access is abandoned with no done.
REQ-035 Reset release SHALL take effect on the first rising clk edge with rst_n=1.

Verification
REQ-036 start, no mem op, alu_in=16'h1234 -> next cycle done=1, wb_data=16'h1234, err=0, dmem_req never 1.
REQ-037 load alu_in=16'h0040, ack after 3 REQ cycles with dmem_rdata=16'hBEEF -> dmem_addr=16'h0040 stable throughout, done with wb_data=16'hBEEF.
REQ-038 store alu_in=16'h0010, wr_data=16'h00A5, ack in first cycle -> dmem_we=1, dmem_wdata=16'h00A5, done 2 cycles after start, err=0.
REQ-039 load alu_in=16'h0011 -> no dmem_req, done=1, err=1; load alu_in=16'h0020, ack never -> done with err=1 after TIMEOUT REQ cycles.
REQ-040 rst_n=0 mid-REQ -> dmem_req/busy/done immediately 0; halt start -> halted=1, later starts ignored until reset.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage of a simple in-order pipeline.
//
// Accepts one operation per start pulse from the execute stage and either
// passes the ALU result straight through, performs a load/store on the data
// memory with a bounded wait for dmem_ack, rejects an illegal access, or halts.
// Every output is a register updated by the single state machine below.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle operation-valid pulse
//   mem_read/mem_write  load / store request (sampled with start)
//   halt                halt request (sampled with start, highest priority)
//   alu_in              address for load/store, passthrough data otherwise
//   wr_data             store data
//   dmem_req/we/addr/wdata  data-memory request, held stable while waiting
//   dmem_rdata/ack      data-memory read data and completion strobe
//   wb_data             writeback result, valid with done, held until next done
//   done                one-cycle completion pulse
//   busy                state is not IDLE
//   err                 error flag, qualified by done
//   halted              sticky halt indicator, cleared only by reset
module memory_stage #(
  parameter int unsigned TIMEOUT = 16  // max REQ cycles awaiting ack, 2..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        halt,
  input  logic [15:0] alu_in,
  input  logic [15:0] wr_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [15:0] wb_data,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic        halted
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StHalted = 2'd2
  } state_e;

  // Wait-counter value at which the access is abandoned.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  wait_cnt_q;

  logic is_mem;
  logic bad_op;

  always_comb begin
    is_mem = mem_read | mem_write;
    // Both directions at once, or a misaligned halfword address.
    bad_op = (mem_read & mem_write) | (is_mem & alu_in[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 16'h0000;
      dmem_wdata <= 16'h0000;
      wb_data    <= 16'h0000;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      halted     <= 1'b0;
    end else begin
      // done/err are pulses; wb_data holds its last value.
      done <= 1'b0;
      err  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (halt) begin
              state_q <= StHalted;
              busy    <= 1'b1;
              halted  <= 1'b1;
              done    <= 1'b1;
              wb_data <= alu_in;
            end else if (bad_op) begin
              done    <= 1'b1;
              err     <= 1'b1;
              wb_data <= 16'h0000;
            end else if (is_mem) begin
              state_q    <= StReq;
              busy       <= 1'b1;
              wait_cnt_q <= 8'd0;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= alu_in;
              dmem_wdata <= mem_write ? wr_data : 16'h0000;
            end else begin
              done    <= 1'b1;
              wb_data <= alu_in;
            end
          end
        end

        StReq: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (dmem_ack || (wait_cnt_q == WaitLast)) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 16'h0000;
            dmem_wdata <= 16'h0000;
            done       <= 1'b1;
            err        <= ~dmem_ack;
            wb_data    <= (dmem_ack && !dmem_we) ? dmem_rdata : 16'h0000;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        StHalted: begin
          // Terminal until reset.
          busy <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mem_read, mem_write, halt;
  logic [15:0] alu_in, wr_data;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic [15:0] wb_data;
  logic        done, busy, err, halted;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: last value delivered with done.
  logic [15:0] exp_wb = 16'h0000;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .halt       (halt),
    .alu_in     (alu_in),
    .wr_data    (wr_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .wb_data    (wb_data),
    .done       (done),
    .busy       (busy),
    .err        (err),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; mem_read = 0; mem_write = 0; halt = 0;
    alu_in = 16'h0000; wr_data = 16'h0000; dmem_ack = 0; dmem_rdata = 16'h0000;
  endtask

  // One operation from start to done. ack_delay = index of the REQ cycle in
  // which ack is driven; values >= TO mean the memory never answers in time.
  task automatic do_op(input bit rd, input bit wr, input bit hl, input logic [15:0] addr,
                       input logic [15:0] wdat, input int ack_delay,
                       input logic [15:0] rdat);
    bit          mem_op, bad;
    bit          got_done;
    int          cycles, exp_cycles;
    bit          exp_err;
    logic [15:0] exp_data;

    mem_op = (rd || wr) && !hl;
    bad    = mem_op && ((rd && wr) || addr[0]);

    start = 1; mem_read = rd; mem_write = wr; halt = hl; alu_in = addr; wr_data = wdat;
    tick();
    start = 0; mem_read = 0; mem_write = 0; halt = 0;
    alu_in = 16'($urandom); wr_data = 16'($urandom);

    if (hl) begin
      exp_wb = addr;
      check_eq("halt_done", done, 1);
      check_eq("halt_err", err, 0);
      check_eq("halt_wb", wb_data, exp_wb);
      check_eq("halt_flag", halted, 1);
      check_eq("halt_busy", busy, 1);
      return;
    end

    if (!mem_op || bad) begin
      exp_wb = bad ? 16'h0000 : addr;
      check_eq(bad ? "bad_done" : "pass_done", done, 1);
      check_eq(bad ? "bad_err" : "pass_err", err, bad);
      check_eq(bad ? "bad_wb" : "pass_wb", wb_data, exp_wb);
      check_eq("nomem_req", dmem_req, 0);
      check_eq("nomem_busy", busy, 0);
    end else begin
      check_eq("req_up", dmem_req, 1);
      check_eq("req_we", dmem_we, wr);
      check_eq("req_addr", dmem_addr, addr);
      check_eq("req_wdata", dmem_wdata, wr ? wdat : 16'h0000);
      check_eq("req_nodone", done, 0);
      check_eq("req_busy", busy, 1);

      got_done = 0;
      cycles   = 0;
      for (int k = 0; k < TO + 4 && !got_done; k++) begin
        dmem_ack   = (k == ack_delay);
        dmem_rdata = (k == ack_delay) ? rdat : 16'($urandom);
        // Stray start while busy must be ignored.
        start = ($urandom_range(0, 2) == 0);
        mem_read = 1'($urandom); mem_write = 1'($urandom); halt = 1'($urandom);
        alu_in = 16'($urandom); wr_data = 16'($urandom);
        tick();
        cycles++;
        start = 0; halt = 0; mem_read = 0; mem_write = 0; dmem_ack = 0;
        if (done) got_done = 1;
        else begin
          check_eq("hold_req", dmem_req, 1);
          check_eq("hold_addr", dmem_addr, addr);
          check_eq("hold_we", dmem_we, wr);
        end
      end

      exp_cycles = (ack_delay < TO) ? ack_delay + 1 : TO;
      exp_err    = (ack_delay >= TO);
      exp_data   = (!exp_err && rd) ? rdat : 16'h0000;
      exp_wb     = exp_data;
      check_eq("mem_done_seen", got_done, 1);
      check_eq("mem_latency", cycles, exp_cycles);
      check_eq("mem_err", err, exp_err);
      check_eq("mem_wb", wb_data, exp_wb);
      check_eq("mem_req_drop", dmem_req, 0);
      check_eq("mem_busy_drop", busy, 0);
      check_eq("mem_halted", halted, 0);
    end

    // Following idle cycle: done must fall, wb_data must hold, stray ack ignored.
    dmem_ack = 1'($urandom); dmem_rdata = 16'($urandom);
    tick();
    dmem_ack = 0;
    check_eq("post_done", done, 0);
    check_eq("post_wb_hold", wb_data, exp_wb);
    check_eq("post_req", dmem_req, 0);
  endtask

  initial begin
    int          kind;
    logic [15:0] a;

    idle_inputs();
    rst_n = 0;
    #23;
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_wb", wb_data, 16'h0000);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // Directed scenarios.
    do_op(0, 0, 0, 16'h1234, 16'h0000, 0, 16'h0000);         // passthrough
    do_op(1, 0, 0, 16'h0040, 16'h0000, 3, 16'hBEEF);         // load, ack after 3 waits
    do_op(0, 1, 0, 16'h0010, 16'h00A5, 0, 16'h0000);         // store, ack at once
    do_op(1, 0, 0, 16'h0011, 16'h0000, 0, 16'h0000);         // misaligned load
    do_op(1, 1, 0, 16'h0020, 16'h0000, 0, 16'h0000);         // read and write
    do_op(1, 0, 0, 16'h0020, 16'h0000, 1000, 16'h0000);      // never acked
    do_op(1, 0, 0, 16'h0022, 16'h0000, TO - 1, 16'h5A5A);    // ack on the timeout cycle
    do_op(0, 1, 0, 16'h0024, 16'h1111, TO, 16'h0000);        // ack one cycle too late

    // Randomized operations.
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      a    = 16'($urandom);
      case (kind)
        0, 1: do_op(0, 0, 0, a, 16'($urandom), 0, 16'h0000);
        2, 3, 4: do_op(1, 0, 0, {a[15:1], 1'b0}, 16'($urandom),
                       $urandom_range(0, TO + 1), 16'($urandom));
        5, 6, 7: do_op(0, 1, 0, {a[15:1], 1'b0}, 16'($urandom),
                       $urandom_range(0, TO + 1), 16'($urandom));
        8: do_op(1, 1, 0, a, 16'($urandom), 0, 16'h0000);
        default: do_op(1'($urandom), 1'($urandom) | ~a[0], 0, {a[15:1], 1'b1},
                       16'($urandom), 0, 16'h0000);
      endcase
    end

    // Reset in the middle of a REQ wait: outputs drop without a clock edge.
    start = 1; mem_read = 1; alu_in = 16'h0080;
    tick();
    start = 0; mem_read = 0;
    check_eq("mid_req_up", dmem_req, 1);
    tick();
    tick();
    rst_n = 0;
    #1;
    check_eq("mid_rst_req", dmem_req, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_wb", wb_data, 16'h0000);
    exp_wb = 16'h0000;
    dmem_ack = 1; dmem_rdata = 16'hDEAD;
    tick();
    dmem_ack = 0;
    rst_n = 1;
    tick();
    check_eq("after_rst_done", done, 0);
    check_eq("after_rst_busy", busy, 0);
    do_op(0, 0, 0, 16'h4321, 16'h0000, 0, 16'h0000);

    // Halt is sticky; later starts are ignored until reset.
    do_op(1, 1, 1, 16'h7777, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      start = 1; mem_read = 1'($urandom); mem_write = 1'($urandom);
      alu_in = 16'($urandom);
      tick();
      start = 0;
      tick();
      check_eq("halted_done", done, 0);
      check_eq("halted_busy", busy, 1);
      check_eq("halted_flag", halted, 1);
      check_eq("halted_req", dmem_req, 0);
      check_eq("halted_wb", wb_data, 16'h7777);
    end
    idle_inputs();
    rst_n = 0;
    #1;
    check_eq("unhalt_flag", halted, 0);
    check_eq("unhalt_busy", busy, 0);
    tick();
    rst_n = 1;
    tick();
    exp_wb = 16'h0000;
    do_op(0, 0, 0, 16'h0F0F, 16'h0000, 0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
